// File: rtl/tick_pkg.sv
// Shared types and default constants for the tick_scheduler timebase.
// The config FSM state encoding and the channel-index width helper live here.
package tick_pkg;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  localparam int TICK_NCH      = 4;
  localparam int TICK_PRESCALE = 50_000;
  localparam int TICK_CW       = 16;

  // Channel-select width; a single-channel build still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: counts advance strobes, pulses tick and toggles
// clk_out on each wrap, with load/disable/period-update strobes from the top.
module tick_channel
  import tick_pkg::*;
#(
  parameter int CW = TICK_CW
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          base_tick,
  input  logic          load,
  input  logic          dis,
  input  logic          upd,
  input  logic [CW-1:0] period_in,
  output logic          tick,
  output logic          clk_out,
  output logic          wrap,
  output logic          enabled
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  logic          en;

  // period is never zero while en is set, so period-1 cannot underflow here.
  assign wrap    = base_tick && en && (cnt == period - CW'(1));
  assign enabled = en;

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      period  <= '0;
      en      <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (dis) begin
        en      <= 1'b0;
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (load) begin
        en     <= 1'b1;
        cnt    <= '0;
        period <= period_in;
      end else if (wrap) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= ~clk_out;
        if (upd) period <= period_in;
      end else if (base_tick && en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel timebase: shared prescaler, NCH tick_channel instances and a
// valid/ready config FSM that defers period changes on running channels to their wrap.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter  int NCH      = TICK_NCH,
  parameter  int PRESCALE = TICK_PRESCALE,
  parameter  int CW       = TICK_CW,
  localparam int CHW      = ch_width(NCH)
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_en,
  output logic           base_tick,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out
);

  localparam int             PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]  pre_cnt;
  logic           pre_wrap;

  cfg_state_t     state, next_state;
  logic [CHW-1:0] shadow_ch;
  logic [CW-1:0]  shadow_period;
  logic [CW-1:0]  period_bus;

  logic           accept;
  logic           ch_ok;
  logic           eff_en;
  logic           latch;
  logic [NCH-1:0] en_vec, wrap_vec, load_vec, dis_vec, upd_vec;

  assign pre_wrap = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      pre_cnt   <= pre_wrap ? '0 : pre_cnt + PW'(1);
      base_tick <= pre_wrap;
    end
  end

  generate
    if ((1 << CHW) > NCH) begin : g_ch_range
      assign ch_ok = (cfg_ch < CHW'(NCH));
    end else begin : g_ch_full
      assign ch_ok = 1'b1;
    end
  endgenerate

  assign eff_en     = cfg_en && (cfg_period != '0);
  assign period_bus = (state == CFG_PEND) ? shadow_period : cfg_period;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    cfg_ready  = (state == CFG_IDLE);
    accept     = cfg_valid && cfg_ready;
    latch      = 1'b0;
    load_vec   = '0;
    dis_vec    = '0;
    upd_vec    = '0;
    case (state)
      CFG_IDLE: begin
        if (accept && ch_ok) begin
          if (!eff_en) begin
            dis_vec[cfg_ch] = 1'b1;
          end else if (!en_vec[cfg_ch]) begin
            load_vec[cfg_ch] = 1'b1;
          end else begin
            latch      = 1'b1;
            next_state = CFG_PEND;
          end
        end
      end
      CFG_PEND: begin
        // Only a wrap after the accept cycle can complete the update.
        if (wrap_vec[shadow_ch]) begin
          upd_vec[shadow_ch] = 1'b1;
          next_state         = CFG_IDLE;
        end
      end
      default: next_state = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CFG_IDLE;
      shadow_ch     <= '0;
      shadow_period <= '0;
    end else begin
      state <= next_state;
      if (latch) begin
        shadow_ch     <= cfg_ch;
        shadow_period <= cfg_period;
      end
    end
  end

  // Channels advance on the prescaler terminal so their registered tick and
  // clk_out land in the same cycle as the registered base_tick.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(.CW(CW)) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .base_tick (pre_wrap),
      .load      (load_vec[i]),
      .dis       (dis_vec[i]),
      .upd       (upd_vec[i]),
      .period_in (period_bus),
      .tick      (tick[i]),
      .clk_out   (clk_out[i]),
      .wrap      (wrap_vec[i]),
      .enabled   (en_vec[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, NCH=4, CW=8.
module tb_tick_scheduler;

  localparam int NCH      = 4;
  localparam int PRESCALE = 4;
  localparam int CW       = 8;

  logic           clk_in     = 1'b0;
  logic           rst_n      = 1'b0;
  logic           cfg_valid  = 1'b0;
  logic [1:0]     cfg_ch     = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_en     = 1'b0;
  logic           cfg_ready;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;

  int checks = 0;
  int passes = 0;

  always #5 clk_in = ~clk_in;

  tick_scheduler #(.NCH(NCH), .PRESCALE(PRESCALE), .CW(CW)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
    .base_tick  (base_tick),
    .tick       (tick),
    .clk_out    (clk_out)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic release_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int period, input logic en);
    int waited = 0;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(period);
    cfg_en     = en;
    cfg_valid  = 1'b1;
    while (!cfg_ready && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    checks++;
    if (cfg_ready !== 1'b1)
      $display("FAIL cfg_accept ch%0d: cfg_ready=%b after %0d cycles, required 1", ch, cfg_ready, waited);
    else passes++;
    @(posedge clk_in);
    #1 cfg_valid = 1'b0;
  endtask

  // Cycles until the next tick on ch, and how many of them had clk_out high.
  task automatic measure_gap(input int ch, output int gap, output int high);
    gap  = 0;
    high = 0;
    do begin
      if (clk_out[ch]) high++;
      @(negedge clk_in);
      gap++;
    end while (!tick[ch] && gap < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({base_tick, tick, clk_out, cfg_ready} !== 10'b0_0000_0000_1)
      $display("FAIL reset_state: bt/tick/clk/rdy=%b, required 0000000001", {base_tick, tick, clk_out, cfg_ready});
    else passes++;
    release_reset();
    cfg_write(0, 1, 1'b1);
    repeat (10) @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({base_tick, tick, clk_out, cfg_ready} !== 10'b0_0000_0000_1)
      $display("FAIL midrun_reset: bt/tick/clk/rdy=%b, required 0000000001", {base_tick, tick, clk_out, cfg_ready});
    else passes++;
    release_reset();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if (base_tick !== ((k % PRESCALE) == 0))
        $display("FAIL base_cadence cycle %0d: base_tick=%b, required %b", k, base_tick, (k % PRESCALE) == 0);
      else passes++;
    end
  endtask

  task automatic test_enable();
    int g, h;
    @(negedge clk_in);
    cfg_write(0, 3, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL enable_ready: cfg_ready=%b, required 1", cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    measure_gap(0, g, h);
    checks++;
    if (g !== 12 || h !== 12 || clk_out[0] !== 1'b0)
      $display("FAIL enable_high: gap=%0d high=%0d clk=%b, required 12 12 0", g, h, clk_out[0]);
    else passes++;
    measure_gap(0, g, h);
    checks++;
    if (g !== 12 || h !== 0 || clk_out[0] !== 1'b1)
      $display("FAIL enable_low: gap=%0d high=%0d clk=%b, required 12 0 1", g, h, clk_out[0]);
    else passes++;
  endtask

  task automatic test_glitch_free_change();
    int g, h;
    cfg_write(0, 5, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL pend_ready: cfg_ready=%b, required 0", cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    checks++;
    if (g !== 11 || cfg_ready !== 1'b1)
      $display("FAIL change_first_gap: gap=%0d rdy=%b, required 11 1", g, cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    checks++;
    if (g !== 20) $display("FAIL change_new_gap: gap=%0d, required 20", g);
    else passes++;
    // Accept lands on the wrap edge: that wrap must not complete the update.
    repeat (19) @(negedge clk_in);
    cfg_write(0, 2, 1'b1);
    @(negedge clk_in);
    checks++;
    if (tick[0] !== 1'b1 || cfg_ready !== 1'b0)
      $display("FAIL coincident_wrap: tick0=%b rdy=%b, required 1 0", tick[0], cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    checks++;
    if (g !== 20 || cfg_ready !== 1'b1)
      $display("FAIL coincident_old_gap: gap=%0d rdy=%b, required 20 1", g, cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    checks++;
    if (g !== 8) $display("FAIL coincident_new_gap: gap=%0d, required 8", g);
    else passes++;
  endtask

  task automatic test_immediate_disable();
    int w = 0;
    int n0 = 0, n1 = 0, n2 = 0, n3 = 0, h2 = 0;
    cfg_write(1, 1, 1'b1);
    cfg_write(2, 2, 1'b1);
    cfg_write(3, 3, 1'b1);
    while (!clk_out[2] && w < 60) begin
      @(negedge clk_in);
      w++;
    end
    checks++;
    if (clk_out[2] !== 1'b1) $display("FAIL ch2_start: clk_out2=%b, required 1", clk_out[2]);
    else passes++;
    cfg_write(2, 2, 1'b0);
    @(negedge clk_in);
    checks++;
    if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0)
      $display("FAIL disable_now: clk2=%b tick2=%b, required 0 0", clk_out[2], tick[2]);
    else passes++;
    repeat (24) begin
      @(negedge clk_in);
      if (tick[0]) n0++;
      if (tick[1]) n1++;
      if (tick[2]) n2++;
      if (tick[3]) n3++;
      if (clk_out[2]) h2++;
    end
    checks++;
    if (n0 !== 3 || n1 !== 6 || n2 !== 0 || n3 !== 2 || h2 !== 0)
      $display("FAIL disable_window: ticks=%0d/%0d/%0d/%0d clk2_high=%0d, required 3/6/0/2 0", n0, n1, n2, n3, h2);
    else passes++;
  endtask

  task automatic test_period_zero();
    int n = 0;
    cfg_write(1, 5, 1'b0);
    cfg_write(1, 0, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL p0_idle_ready: cfg_ready=%b, required 1", cfg_ready);
    else passes++;
    cfg_write(3, 0, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1 || clk_out[3] !== 1'b0)
      $display("FAIL p0_running: rdy=%b clk3=%b, required 1 0", cfg_ready, clk_out[3]);
    else passes++;
    repeat (24) begin
      @(negedge clk_in);
      if (tick[1] || tick[3] || clk_out[1] || clk_out[3]) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL p0_silent: active cycles=%0d, required 0", n);
    else passes++;
  endtask

  task automatic test_reset_in_pend();
    int g, h;
    int n = 0;
    measure_gap(0, g, h);
    cfg_write(0, 6, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL rp_pend: cfg_ready=%b, required 0", cfg_ready);
    else passes++;
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || clk_out !== 4'b0 || tick !== 4'b0)
      $display("FAIL rp_reset: rdy=%b clk=%b tick=%b, required 1 0000 0000", cfg_ready, clk_out, tick);
    else passes++;
    release_reset();
    repeat (12) begin
      @(negedge clk_in);
      if (tick != 4'b0) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL rp_ch_disabled: tick cycles=%0d, required 0", n);
    else passes++;
    cfg_write(0, 2, 1'b1);
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL rp_immediate: cfg_ready=%b, required 1", cfg_ready);
    else passes++;
    measure_gap(0, g, h);
    measure_gap(0, g, h);
    checks++;
    if (g !== 8) $display("FAIL rp_gap: gap=%0d, required 8", g);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_glitch_free_change();
    test_immediate_disable();
    test_period_zero();
    test_reset_in_pend();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Programmable multi-channel timebase controller for the display/game logic. One shared prescaler divides `clk_in` into a base tick. `NCH` independent channels count base ticks to produce per-channel tick pulses and divided square clocks. A valid/ready config port sets each channel's period and enable. Period changes on a running channel take effect only at that channel's next wrap, so no divided clock ever shows a shortened phase.

## Interface
- `NCH`, 4, number of channels (≥1).
- `PRESCALE`, 50_000, `clk_in` cycles per base tick (≥2); 50 MHz → 1 kHz.
- `CW`, 16, channel period/counter width.

- `clk_in` in 1: sole clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `cfg_ch` in `$clog2(NCH)` (min 1): target channel; values ≥ NCH are accepted and ignored.
- `cfg_period` in CW: period in base ticks.
- `cfg_en` in 1: channel enable.
- `base_tick` out 1: one-cycle pulse every PRESCALE cycles.
- `tick` out NCH: one-cycle pulse per channel wrap.
- `clk_out` out NCH: per-channel square wave, toggles on each wrap.

## Operation
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and is free-running.
  - `base_tick` is registered: high for one cycle after the cycle in which `pre_cnt == PRESCALE-1`.
- Channel state: `cnt`, `period`, `en`.
  - On a base_tick cycle with `en`: if `cnt == period-1`, then `cnt ← 0`, `tick` pulses and `clk_out` toggles; otherwise `cnt ← cnt+1`.
  - Period 1 gives a wrap on every base tick.
- Effective enable is `cfg_en && cfg_period != 0`. Writing period 0 is a disable.
- Config FSM states:
  - `CFG_IDLE`: `cfg_ready = 1`. On accept:
    - Target disabled, or effective enable = 0: apply next cycle and stay in `CFG_IDLE`.
      - Disable: `en←0`, `cnt←0`, `clk_out←0`.
      - Enable of an idle channel: `period` loaded, `cnt←0`, `clk_out` unchanged (0); counting starts at the next base_tick.
    - Target enabled and new effective enable = 1: latch `ch`/`period` into a shadow register and go to `CFG_PEND`.
  - `CFG_PEND`: `cfg_ready = 0`.
    - On the target's next wrap, the wrap completes normally (tick, toggle, `cnt←0`) and `period ← shadow` in the same cycle. Then go to `CFG_IDLE`.
    - Worst-case stall is `old_period × PRESCALE` cycles.
- Same-period rewrite to an enabled channel still waits for the wrap; it has no other effect.
- A wrap coinciding with the accept cycle does not count. PEND waits for the following wrap.
- Other channels run undisturbed in every state.

## Timing
- Reset values:
  - `base_tick`, `tick`, `clk_out` = 0.
  - `cfg_ready` = 1 (FSM in `CFG_IDLE`).
  - All counters, periods and enables = 0.
  - Shadow register is discarded.
- First `base_tick` occurs PRESCALE cycles after `rst_n` deasserts.
- `tick[i]` and the `clk_out[i]` toggle land in the same cycle as the `base_tick` pulse that wraps the channel (all registered, one cycle after `pre_cnt` terminal).
- Steady-state `tick` spacing is `period × PRESCALE` cycles. `clk_out` period is twice that.
- Immediate-apply config is visible on outputs 1 cycle after accept.
- Reset mid-PEND aborts the update; the old and new periods are both lost.
- Counter widths:
  - `pre_cnt` is `$clog2(PRESCALE)` bits.
  - `cnt`/`period` are CW bits; `period-1` is computed in CW bits and never evaluated for period 0.

## Structure
- Package `tick_pkg`:
  - `typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t`.
  - Default constants `TICK_NCH`, `TICK_PRESCALE`, `TICK_CW`.
- Sub-module `tick_channel`, generated NCH times.
  - Inputs: `base_tick`, load/disable strobes, `period_in`.
  - Outputs: `tick`, `clk_out`, `wrap`.
- Top level holds the prescaler, config FSM and shadow register.

## Test plan
Bench uses PRESCALE=4, NCH=4, CW=8.

- **Reset:** `rst_n=0` mid-run → all outputs 0, `cfg_ready=1`. After release, `base_tick` first rises at cycle 4, then every 4 cycles.
- **Enable:** cfg ch0, period 3, en 1 on a disabled channel → `cfg_ready` stays 1. `tick[0]` every 12 cycles; `clk_out[0]` high 12 / low 12.
- **Glitch-free change:** ch0 running at period 3, write period 5 → `cfg_ready=0` until the next ch0 wrap. Successive tick gaps are 12, then 20; no gap is below 12.
- **Immediate disable:** ch2 running with `clk_out[2]=1`, write en 0 → `clk_out[2]=0` and `tick[2]` silent from the next cycle; channels 0, 1, 3 unaffected.
- **Period 0:** write ch1 period 0, en 1 → ch1 stays disabled, no PEND.
- **Reset in PEND:** assert `rst_n` while PEND on ch0 → `cfg_ready=1` and ch0 disabled. A subsequent period-2 write applies immediately.
